// File: rtl/mdu_param.sv
// Multi-cycle multiply / multiply-accumulate / divide unit holding HI/LO.
// Results are computed at launch; only the commit edge is architecturally visible.
module mdu_param #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'd0;
    localparam logic [3:0] OpMultu = 4'd1;
    localparam logic [3:0] OpDiv   = 4'd2;
    localparam logic [3:0] OpDivu  = 4'd3;
    localparam logic [3:0] OpMthi  = 4'd4;
    localparam logic [3:0] OpMtlo  = 4'd5;
    localparam logic [3:0] OpMadd  = 4'd6;
    localparam logic [3:0] OpMaddu = 4'd7;
    localparam logic [3:0] OpMsub  = 4'd8;
    localparam logic [3:0] OpMsubu = 4'd9;

    typedef enum logic {StIdle, StRun} state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [3:0]           op_q;
    logic [2*WIDTH-1:0]   res_q;
    logic                 div_zero_q;

    // Launch-time decode and datapath
    logic                 op_signed, op_div, op_launch;
    logic [2*WIDTH-1:0]   a_ext, b_ext, prod, launch_res;
    logic                 b_zero, div_ovf;
    logic [WIDTH-1:0]     b_safe, quot_u, rem_u;
    logic signed [WIDTH-1:0] a_s, b_s, quot_s, rem_s;

    always_comb begin
        op_signed = 1'b0;
        op_div    = 1'b0;
        op_launch = 1'b0;
        case (op)
            OpMult, OpMadd, OpMsub: begin
                op_signed = 1'b1;
                op_launch = 1'b1;
            end
            OpMultu, OpMaddu, OpMsubu: op_launch = 1'b1;
            OpDiv: begin
                op_signed = 1'b1;
                op_div    = 1'b1;
                op_launch = 1'b1;
            end
            OpDivu: begin
                op_div    = 1'b1;
                op_launch = 1'b1;
            end
            default: ;
        endcase

        a_ext = op_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext = op_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod  = a_ext * b_ext;

        // Dividing by one instead of zero or -1 keeps the divider defined; for
        // most-negative / -1 it also yields exactly quotient=a, remainder=0.
        b_zero  = (b == '0);
        div_ovf = op_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        b_safe  = (b_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;

        a_s    = $signed(a);
        b_s    = $signed(b_safe);
        quot_s = a_s / b_s;
        rem_s  = a_s % b_s;
        quot_u = a / b_safe;
        rem_u  = a % b_safe;

        if (op_div) begin
            launch_res = op_signed ? {rem_s, quot_s} : {rem_u, quot_u};
        end else begin
            launch_res = prod;
        end
    end

    // Commit value, using HI/LO as they stand at the commit edge
    logic [2*WIDTH-1:0] acc, commit_val;

    always_comb begin
        acc = {hi, lo};
        case (op_q)
            OpMadd, OpMaddu: commit_val = acc + res_q;
            OpMsub, OpMsubu: commit_val = acc - res_q;
            OpDiv, OpDivu:   commit_val = div_zero_q ? acc : res_q;
            default:         commit_val = res_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            res_q      <= '0;
            div_zero_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && !cancel) begin
                        if (op_launch) begin
                            op_q       <= op;
                            res_q      <= launch_res;
                            div_zero_q <= op_div && b_zero;
                            cnt_q      <= op_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                            state_q    <= StRun;
                            busy       <= 1'b1;
                        end else if (op == OpMthi) begin
                            hi <= a;
                        end else if (op == OpMtlo) begin
                            lo <= a;
                        end
                    end
                end
                StRun: begin
                    if (cancel) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                    end else if (cnt_q == CntW'(1)) begin
                        {hi, lo} <= commit_val;
                        state_q  <= StIdle;
                        cnt_q    <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mdu_param.md
# mdu_param

Parametrised multiply/divide unit for the pipelined MIPS core, sitting in the E stage beside the ALU and driven by the decoded MD control code and the forwarded operands. It runs a multi-cycle multiply, multiply-accumulate or divide and holds HI/LO. It exposes a start/busy handshake that the stall controller consumes, and accepts a cancel from the exception logic so that a flushed instruction never commits to HI/LO. Latencies and datapath width are parameters.

## Interface
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for multiply and multiply-accumulate; must be ≥1
- DIV_CYCLES, 10, busy cycles for divide; must be ≥1
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset; 0 resets the unit
- start  in  1  launch the operation in `op`; sampled on the rising edge
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; 10–15 are no-ops
- a  in  WIDTH  operand rs
- b  in  WIDTH  operand rt
- cancel  in  1  exception flush; kills a same-cycle start and aborts an in-flight operation
- busy  out  1  operation in flight (registered)
- done  out  1  one-cycle pulse after an operation commits
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- The unit has two states, IDLE and RUN, and a down-counter of width clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- **IDLE, start=1, cancel=0:**
  - Ops 0–3 and 6–9: latch the op and operands, load the counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
  - MTHI/MTLO: write a into hi or lo at this edge. The state stays IDLE, busy stays 0 and done does not pulse.
  - Ops 10–15: ignored.
- **IDLE, start=1, cancel=1:** nothing happens, including for MTHI/MTLO.
- **RUN:** the counter decrements each edge. At the edge where it reaches 0, the unit commits the result to hi/lo, returns to IDLE and sets done for the following cycle.
- **start while RUN:** ignored. The stall controller guarantees this does not happen; the verification bench checks that it is ignored.
- **cancel while RUN:** return to IDLE at the next edge. hi/lo are unchanged and done stays 0.
- **Result definitions** (P = 2·WIDTH-bit product; signedness taken from the op):
  - MULT/MULTU: {hi,lo}=P.
  - MADD/MADDU: {hi,lo}={hi,lo}+P, modulo 2^(2·WIDTH).
  - MSUB/MSUBU: {hi,lo}={hi,lo}−P, modulo 2^(2·WIDTH).
  - Accumulate ops use the hi/lo value present at commit. No other write to hi/lo can occur during RUN.
  - DIV/DIVU: lo=quotient, hi=remainder. The quotient truncates toward zero and the remainder takes the sign of the dividend.
- **Divide boundary cases:**
  - Divide by zero: hi/lo unchanged. The full DIV_CYCLES busy period and the done pulse still occur.
  - Signed most-negative ÷ −1: lo=most-negative, hi=0.
- The computation may be done at launch and held in a register. Only the commit timing is architecturally visible.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0. Reset during RUN aborts with no commit.
- Start accepted at edge E0:
  - busy=1 from E0 through edge E_N, where N = MULT_CYCLES or DIV_CYCLES, i.e. exactly N cycles.
  - hi/lo update at E_N, and busy=0 after E_N.
  - done=1 for the cycle after E_N.
- MTHI/MTLO: hi/lo are visible the cycle after the start edge.
- Back-to-back: start may be accepted in the same cycle done is high. That start is sampled at edge E_N+1 and the next busy period begins then.
- cancel sampled with busy=1 at edge Ec: busy=0 after Ec. cancel overrides a commit that falls on the same edge.
- busy depends only on state, with no combinational path from start. The stall controller must OR start into its own stall term.

## Test plan
- Reset low, then MULT a=0xFFFFFFFE, b=3 → busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- MTHI 5, MTLO 7, then MADD a=2, b=3 → hi=5, lo=13. Then MSUBU a=1, b=14 → hi=4, lo=0xFFFFFFFF.
- DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles. DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0. DIVU by 0 → hi/lo unchanged, 10 busy cycles.
- DIV started, cancel at busy cycle 4 → busy low next cycle, hi/lo unchanged, no done. start+cancel together with MTLO 9 → lo unchanged.
- Reset asserted mid-MULT → all outputs 0 immediately. Start during busy → ignored; the result and timing match a single operation.
